sram_bus_arbiter: RTL

SRAM_BUS_ARBITER -- requirements
Module: sram_bus_arbiter

---
 rtl/bus_arb_pkg.sv | 18 +
 rtl/arb_tag_fifo.sv | 63 ++++++
 rtl/sram_bus_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the SRAM bus arbiter: owner IDs, arbitration states
// and the default outstanding-transaction depth.
package bus_arb_pkg;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ST_FREE        = 2'd0,
        ST_LOCKED_INST = 2'd1,
        ST_LOCKED_DATA = 2'd2
    } arb_state_e;

    localparam int DEFAULT_OUTSTD_DEPTH = 2;

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order owner-tag FIFO: one bit per accepted bus transaction, recording
// which port must receive the matching data response.
module arb_tag_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Two-port (instruction/data) to single SRAM-like bus arbiter with address-phase
// locking and in-order response routing. Define ARB_ROUND_ROBIN_EN for round-robin ties.
module sram_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int OUTSTD_DEPTH = DEFAULT_OUTSTD_DEPTH
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    arb_state_e state;
    owner_e     owner;
    owner_e     tie_winner;
    owner_e     head_owner;
    logic       any_req;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_head;
    logic       push;
    logic       pop;

`ifdef ARB_ROUND_ROBIN_EN
    owner_e last_owner;

    // Reset to "instruction went last" so data wins the first tie.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_owner <= OWN_INST;
        end else if (push) begin
            last_owner <= owner;
        end
    end

    assign tie_winner = (last_owner == OWN_DATA) ? OWN_INST : OWN_DATA;
`else
    assign tie_winner = OWN_DATA;
`endif

    always_comb begin
        owner   = OWN_DATA;
        any_req = 1'b0;
        case (state)
            ST_FREE: begin
                any_req = inst_req | data_req;
                if (inst_req && data_req) begin
                    owner = tie_winner;
                end else if (inst_req) begin
                    owner = OWN_INST;
                end else begin
                    owner = OWN_DATA;
                end
            end
            // A locked owner keeps the bus requested even if it drops req.
            ST_LOCKED_INST: begin
                any_req = 1'b1;
                owner   = OWN_INST;
            end
            ST_LOCKED_DATA: begin
                any_req = 1'b1;
                owner   = OWN_DATA;
            end
            default: begin
                any_req = 1'b0;
                owner   = OWN_DATA;
            end
        endcase
    end

    assign bus_req   = resetn & any_req & ~fifo_full;
    assign bus_wr    = (owner == OWN_DATA) ? data_wr    : inst_wr;
    assign bus_size  = (owner == OWN_DATA) ? data_size  : inst_size;
    assign bus_wstrb = (owner == OWN_DATA) ? data_wstrb : inst_wstrb;
    assign bus_addr  = (owner == OWN_DATA) ? data_addr  : inst_addr;
    assign bus_wdata = (owner == OWN_DATA) ? data_wdata : inst_wdata;

    assign push = bus_req & bus_addr_ok;
    assign pop  = resetn & bus_data_ok & ~fifo_empty;

    assign inst_addr_ok = push & (owner == OWN_INST);
    assign data_addr_ok = push & (owner == OWN_DATA);

    assign head_owner   = owner_e'(fifo_head);
    assign inst_data_ok = pop & (head_owner == OWN_INST);
    assign data_data_ok = pop & (head_owner == OWN_DATA);
    assign inst_rdata   = inst_data_ok ? bus_rdata : 32'd0;
    assign data_rdata   = data_data_ok ? bus_rdata : 32'd0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_FREE;
        end else begin
            case (state)
                ST_FREE: begin
                    if (bus_req && !bus_addr_ok) begin
                        state <= (owner == OWN_DATA) ? ST_LOCKED_DATA : ST_LOCKED_INST;
                    end
                end
                ST_LOCKED_INST, ST_LOCKED_DATA: begin
                    if (push) begin
                        state <= ST_FREE;
                    end
                end
                default: state <= ST_FREE;
            endcase
        end
    end

    arb_tag_fifo #(
        .DEPTH(OUTSTD_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (logic'(owner)),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
